commands_printer_tracker: RTL and testbench
===========================================

COMMANDS_PRINTER_TRACKER -- requirements
Module: commands_printer_tracker

Interface
REQ-001 Parameter BASE_INDEX, default 8'h80: screen-character address of terminal line 0, column 0.
REQ-002 Parameter NUM_LINES, default 4: history depth in lines; BASE_INDEX + NUM_LINES*32 SHALL be <= 256.
REQ-003 clock  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 start  input  1: request to stream the whole history once.
REQ-006 ps2_line_content  input  256: completed command line, 32 ASCII bytes; bits [8c+7:8c] = column c.
REQ-007 ps2_line_ready  input  1: line-complete strobe; a rising edge commits ps2_line_content.
REQ-008 finish  output  1: high when idle and able to accept start.
REQ-009 char_index  output  8: screen-memory write address of the current character.
REQ-010 char_data  output  8: ASCII byte for char_index.

Function
REQ-011 History SHALL hold NUM_LINES lines of 32 bytes; line NUM_LINES-1 is newest (bottom), line 0 is oldest (top).
REQ-012 A ps2_line_ready rising edge (low in previous cycle, high now) SHALL shift history up one line, dropping line 0, and write ps2_line_content into line NUM_LINES-1; a held-high level SHALL NOT cause repeated commits.
REQ-013 States SHALL be IDLE and PRINT; reset enters IDLE.
REQ-014 finish SHALL be combinational: high only in IDLE with start low; it SHALL go low in the same cycle start is asserted.
REQ-015 In IDLE, start sampled high SHALL enter PRINT with counter k=0; start in PRINT SHALL be ignored.
REQ-016 In PRINT, for k = 0 to NUM_LINES*32-1, one character per cycle: char_index = BASE_INDEX + k, char_data = history[k/32] column k%32, both registered.
REQ-017 The first character SHALL be valid on the cycle after start is sampled; the last character SHALL be held for one cycle, then the block returns to IDLE (finish high); a full print takes NUM_LINES*32 cycles.
REQ-018 char_index/char_data SHALL hold their last values while IDLE.
REQ-019 A ready edge during PRINT SHALL be stored in a one-deep pending register and committed in the cycle PRINT ends; a second edge before that commit overwrites the pending line; the in-progress print is never altered.
REQ-020 A ready edge in IDLE coinciding with start SHALL be committed before the print, so the print includes the new line.
REQ-021 index arithmetic is 8-bit; no wrap occurs within a legal BASE_INDEX/NUM_LINES configuration.

Reset
REQ-022 reset SHALL clear all history bytes to 8'h20 and the pending register to empty, set state IDLE, k=0, char_index=BASE_INDEX, char_data=8'h20, and the edge-detect register to 0.
REQ-023 reset during PRINT SHALL abort the print immediately; finish is high in the following cycle if start is low.

Configuration
REQ-024 Macro CPT_NULL_FILTER_EN: when defined, any history byte equal to 8'h00 SHALL be output as 8'h20; when undefined, bytes SHALL be output unmodified.

Verification
REQ-025 Reset, then start one cycle -> finish low that cycle; 128 cycles char_index 8'h80..8'hFF, char_data 8'h20; finish high after.
REQ-026 Commit line "FIRE" (bytes 46,49,52,45, rest 00), then print -> indices 8'hE0..8'hE3 carry 46,49,52,45; 8'hE4..8'hFF carry 20 with CPT_NULL_FILTER_EN, 00 without.
REQ-027 Commit five distinct lines L1..L5, then print -> line order L2,L3,L4,L5 at bases 8'h80,8'hA0,8'hC0,8'hE0.
REQ-028 Hold ps2_line_ready high 10 cycles -> exactly one commit.
REQ-029 Ready edge at print cycle 40 -> print entirely old content; new line visible at 8'hE0 only in the next print.
REQ-030 Assert reset at print cycle 50 -> outputs char_index=8'h80, char_data=8'h20, history all 8'h20, finish high next cycle.

Source files
------------

// File: rtl/commands_printer_tracker.sv
// Keeps the last NUM_LINES PS/2 command lines and streams them into screen memory.
// Optional macro CPT_NULL_FILTER_EN prints 8'h00 history bytes as spaces.
module commands_printer_tracker #(
  parameter logic [7:0] BASE_INDEX = 8'h80,
  parameter int         NUM_LINES  = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] ps2_line_content,
  input  logic         ps2_line_ready,
  output logic         finish,
  output logic [7:0]   char_index,
  output logic [7:0]   char_data
);

  localparam int         HB    = NUM_LINES * 256;
  localparam logic [8:0] TOTAL = 9'(NUM_LINES * 32);

  typedef enum logic {IDLE, PRINT} state_t;

  state_t          state, state_next;
  logic [8:0]      k, k_next;
  logic [HB-1:0]   hist, hist_next;
  logic [HB+255:0] shifted;
  logic [255:0]    pend_line, commit_line;
  logic            pend_valid, pend_set, pend_clr;
  logic            commit_en, load;
  logic            ready_q, ready_edge;
  logic [8:0]      rd_k;
  logic [7:0]      rd_byte, out_byte;

  assign ready_edge = ps2_line_ready & ~ready_q;
  assign finish     = (state == IDLE) && !start;

  // Commits are only allowed while idle or at the very end of a print,
  // so the history never changes under a print in progress.
  always_comb begin
    state_next  = state;
    k_next      = k;
    load        = 1'b0;
    commit_en   = 1'b0;
    commit_line = ps2_line_content;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    case (state)
      IDLE: begin
        commit_en = ready_edge;
        if (start) begin
          state_next = PRINT;
          k_next     = 9'd1;
          load       = 1'b1;
        end
      end
      PRINT: begin
        if (k == TOTAL) begin
          state_next = IDLE;
          k_next     = 9'd0;
          pend_clr   = 1'b1;
          if (ready_edge) begin
            commit_en = 1'b1;
          end else if (pend_valid) begin
            commit_en   = 1'b1;
            commit_line = pend_line;
          end
        end else begin
          load   = 1'b1;
          k_next = k + 9'd1;
          pend_set = ready_edge;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte k of the packed history is line k/32, column k%32; reading from the
  // post-commit view lets a commit coinciding with start appear in the print.
  always_comb begin
    shifted   = {commit_line, hist};
    hist_next = commit_en ? shifted[HB+255:256] : hist;
    rd_k      = (state == PRINT) ? k : 9'd0;
    rd_byte   = 8'(hist_next >> {rd_k, 3'b000});
`ifdef CPT_NULL_FILTER_EN
    out_byte  = (rd_byte == 8'h00) ? 8'h20 : rd_byte;
`else
    out_byte  = rd_byte;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 9'd0;
      hist       <= {(NUM_LINES * 32){8'h20}};
      pend_valid <= 1'b0;
      pend_line  <= '0;
      ready_q    <= 1'b0;
      char_index <= BASE_INDEX;
      char_data  <= 8'h20;
    end else begin
      state   <= state_next;
      k       <= k_next;
      ready_q <= ps2_line_ready;
      hist    <= hist_next;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_line  <= ps2_line_content;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (load) begin
        char_index <= BASE_INDEX + rd_k[7:0];
        char_data  <= out_byte;
      end
    end
  end

endmodule

// File: tb/tb_commands_printer_tracker.sv
// Directed, table-driven bench for commands_printer_tracker (default parameters).
module tb_commands_printer_tracker;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic         finish;
  logic [7:0]   char_index;
  logic [7:0]   char_data;

  int checks = 0;
  int errors = 0;

`ifdef CPT_NULL_FILTER_EN
  localparam logic [7:0] NUL_OUT = 8'h20;
`else
  localparam logic [7:0] NUL_OUT = 8'h00;
`endif

  typedef struct {
    int         k;
    logic [7:0] idx;
    logic [7:0] dat;
  } vec_t;

  vec_t       fire_vec[7];
  vec_t       five_vec[6];
  logic [7:0] model[128];
  logic [7:0] cap_idx[128];
  logic [7:0] cap_dat[128];
  logic [255:0] none_line;

  commands_printer_tracker dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .ps2_line_content(ps2_line_content),
    .ps2_line_ready(ps2_line_ready),
    .finish(finish),
    .char_index(char_index),
    .char_data(char_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input int n);
    logic [255:0] l;
    for (int c = 0; c < 32; c++) l[8*c +: 8] = 8'(16 * n + (c % 16));
    return l;
  endfunction

  function automatic logic [7:0] filt(input logic [7:0] b);
`ifdef CPT_NULL_FILTER_EN
    return (b == 8'h00) ? 8'h20 : b;
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model[i] = 8'h20;
  endtask

  task automatic model_commit(input logic [255:0] l);
    for (int i = 0; i < 96; i++) model[i] = model[i+32];
    for (int c = 0; c < 32; c++) model[96+c] = l[8*c +: 8];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    ps2_line_ready = 1'b0;
    ps2_line_content = '0;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic applyStimulus(input logic [255:0] l);
    ps2_line_content = l;
    ps2_line_ready = 1'b1;
    step();
    ps2_line_ready = 1'b0;
    step();
    model_commit(l);
  endtask

  // One print; optional ready edge coinciding with start, up to two edges
  // during the print (e < 0 disables), and an optional reset at cycle rst_at.
  task automatic run_print(input bit coincide, input logic [255:0] cline,
                           input int e1, input logic [255:0] l1,
                           input int e2, input logic [255:0] l2,
                           input int rst_at);
    bit aborted = 1'b0;
    bit have_pend = 1'b0;
    logic [255:0] pend = '0;
    start = 1'b1;
    if (coincide) begin
      ps2_line_content = cline;
      ps2_line_ready = 1'b1;
      model_commit(cline);
    end
    #1;
    checkOutput("finish_low_on_start", 32'(finish), 32'd0);
    step();
    start = 1'b0;
    ps2_line_ready = 1'b0;
    for (int i = 0; i < 128 && !aborted; i++) begin
      cap_idx[i] = char_index;
      cap_dat[i] = char_data;
      checkOutput($sformatf("idx[%0d]", i), 32'(char_index), 32'(8'h80 + 8'(i)));
      checkOutput($sformatf("dat[%0d]", i), 32'(char_data), 32'(filt(model[i])));
      checkOutput($sformatf("finish_busy[%0d]", i), 32'(finish), 32'd0);
      ps2_line_ready = 1'b0;
      if (i == e1) begin
        ps2_line_content = l1; ps2_line_ready = 1'b1; pend = l1; have_pend = 1'b1;
      end
      if (i == e2) begin
        ps2_line_content = l2; ps2_line_ready = 1'b1; pend = l2; have_pend = 1'b1;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        ps2_line_ready = 1'b0;
        #1;
        model_reset();
        aborted = 1'b1;
        checkOutput("abort_idx", 32'(char_index), 32'h80);
        checkOutput("abort_dat", 32'(char_data), 32'h20);
        checkOutput("abort_finish", 32'(finish), 32'd1);
      end else begin
        step();
      end
    end
    if (!aborted) begin
      ps2_line_ready = 1'b0;
      #1;
      checkOutput("finish_after_print", 32'(finish), 32'd1);
      checkOutput("idx_hold", 32'(char_index), 32'hFF);
      checkOutput("dat_hold", 32'(char_data), 32'(filt(model[127])));
      step();
      checkOutput("idx_hold2", 32'(char_index), 32'hFF);
      if (have_pend) model_commit(pend);
    end
  endtask

  initial begin
    logic [255:0] fire;
    none_line = '0;
    fire = '0;
    fire[7:0] = 8'h46; fire[15:8] = 8'h49; fire[23:16] = 8'h52; fire[31:24] = 8'h45;

    fire_vec[0] = '{0,   8'h80, 8'h20};
    fire_vec[1] = '{96,  8'hE0, 8'h46};
    fire_vec[2] = '{97,  8'hE1, 8'h49};
    fire_vec[3] = '{98,  8'hE2, 8'h52};
    fire_vec[4] = '{99,  8'hE3, 8'h45};
    fire_vec[5] = '{100, 8'hE4, NUL_OUT};
    fire_vec[6] = '{127, 8'hFF, NUL_OUT};

    five_vec[0] = '{0,   8'h80, 8'h20};
    five_vec[1] = '{31,  8'h9F, 8'h2F};
    five_vec[2] = '{33,  8'hA1, 8'h31};
    five_vec[3] = '{79,  8'hCF, 8'h4F};
    five_vec[4] = '{96,  8'hE0, 8'h50};
    five_vec[5] = '{127, 8'hFF, 8'h5F};

    do_reset();
    #1;
    checkOutput("reset_finish", 32'(finish), 32'd1);
    checkOutput("reset_idx", 32'(char_index), 32'h80);
    checkOutput("reset_dat", 32'(char_data), 32'h20);

    $display("[TB] blank print after reset");
    run_print(0, none_line, -1, none_line, -1, none_line, -1);

    $display("[TB] FIRE line");
    applyStimulus(fire);
    run_print(0, none_line, -1, none_line, -1, none_line, -1);
    foreach (fire_vec[v]) begin
      checkOutput($sformatf("fire_idx_k%0d", fire_vec[v].k), 32'(cap_idx[fire_vec[v].k]), 32'(fire_vec[v].idx));
      checkOutput($sformatf("fire_dat_k%0d", fire_vec[v].k), 32'(cap_dat[fire_vec[v].k]), 32'(fire_vec[v].dat));
    end

    $display("[TB] five lines, oldest dropped");
    do_reset();
    for (int n = 1; n <= 5; n++) applyStimulus(mk_line(n));
    run_print(0, none_line, -1, none_line, -1, none_line, -1);
    foreach (five_vec[v]) begin
      checkOutput($sformatf("five_idx_k%0d", five_vec[v].k), 32'(cap_idx[five_vec[v].k]), 32'(five_vec[v].idx));
      checkOutput($sformatf("five_dat_k%0d", five_vec[v].k), 32'(cap_dat[five_vec[v].k]), 32'(five_vec[v].dat));
    end

    $display("[TB] ready held high");
    do_reset();
    ps2_line_content = mk_line(7);
    ps2_line_ready = 1'b1;
    repeat (10) step();
    ps2_line_ready = 1'b0;
    step();
    model_commit(mk_line(7));
    run_print(0, none_line, -1, none_line, -1, none_line, -1);
    checkOutput("held_line2_blank", 32'(cap_dat[64]), 32'h20);
    checkOutput("held_line3_new", 32'(cap_dat[96]), 32'h70);

    $display("[TB] edge during print, then overwritten pending");
    run_print(0, none_line, 40, mk_line(9), -1, none_line, -1);
    run_print(0, none_line, -1, none_line, -1, none_line, -1);
    checkOutput("pend_line3", 32'(cap_dat[96]), 32'h90);
    run_print(0, none_line, 40, mk_line(10), 60, mk_line(11), -1);
    run_print(0, none_line, -1, none_line, -1, none_line, -1);
    checkOutput("overwrite_line3", 32'(cap_dat[96]), 32'hB0);
    checkOutput("overwrite_line2", 32'(cap_dat[64]), 32'h90);

    $display("[TB] edge coinciding with start");
    run_print(1, mk_line(12), -1, none_line, -1, none_line, -1);
    checkOutput("coincide_line3", 32'(cap_dat[97]), 32'hC1);

    $display("[TB] reset mid print");
    run_print(0, none_line, -1, none_line, -1, none_line, 50);
    run_print(0, none_line, -1, none_line, -1, none_line, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
